// File: rtl/quick_spi_pkg.sv
// rtl/quick_spi_pkg.sv - shared FSM encoding, widths and default constants for the SPI sequencer
package quick_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_CAPTURE
    } state_t;

    localparam int unsigned DEF_TX_DEPTH      = 4;
    localparam int unsigned DEF_RX_DEPTH      = 4;
    localparam int unsigned DEF_START_TIMEOUT = 255;
    localparam int unsigned TX_WIDTH          = 16;
    localparam int unsigned RX_WIDTH          = 8;

endpackage

// File: rtl/quick_spi_sequencer_if.sv
// rtl/quick_spi_sequencer_if.sv - transmit/receive streams, SPI master handshake and status
interface quick_spi_sequencer_if;
    import quick_spi_pkg::*;

    logic                tx_valid;
    logic                tx_ready;
    logic [TX_WIDTH-1:0] tx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [RX_WIDTH-1:0] rx_data;
    logic                spi_enable;
    logic [TX_WIDTH-1:0] spi_outgoing_data;
    logic                spi_busy;
    logic [RX_WIDTH-1:0] spi_incoming_data;
    logic                idle;
    logic                timeout_err;

    modport slave (
        input  tx_valid, tx_data, rx_ready, spi_busy, spi_incoming_data,
        output tx_ready, rx_valid, rx_data, spi_enable, spi_outgoing_data, idle, timeout_err
    );

    modport master (
        output tx_valid, tx_data, rx_ready, spi_busy, spi_incoming_data,
        input  tx_ready, rx_valid, rx_data, spi_enable, spi_outgoing_data, idle, timeout_err
    );

endinterface

// File: rtl/quick_spi_fifo.sv
// rtl/quick_spi_fifo.sv - power-of-two FIFO; a push on full is taken when a pop happens in the same cycle
module quick_spi_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty FIFO presents zero so the consumer never sees stale storage.
    assign head    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule

// File: rtl/quick_spi_sequencer.sv
// rtl/quick_spi_sequencer.sv - feeds buffered words to an SPI master and buffers the returned bytes
module quick_spi_sequencer
    import quick_spi_pkg::*;
#(
    parameter int unsigned TX_DEPTH      = DEF_TX_DEPTH,
    parameter int unsigned RX_DEPTH      = DEF_RX_DEPTH,
    parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    quick_spi_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [TX_WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                rdy_q, rdy_d;

    logic                tx_full, tx_empty, tx_push, tx_pop;
    logic [TX_WIDTH-1:0] tx_head;
    logic                rx_full, rx_empty, rx_push, rx_pop;
    logic [RX_WIDTH-1:0] rx_head;

    // rdy_q keeps tx_ready low through reset and raises it on the first clock afterwards.
    assign bus.tx_ready          = rdy_q && !tx_full;
    assign tx_push               = bus.tx_valid && bus.tx_ready;
    assign bus.rx_valid          = !rx_empty;
    assign bus.rx_data           = rx_head;
    assign rx_pop                = bus.rx_valid && bus.rx_ready;
    assign bus.spi_enable        = (state_q == ST_START);
    assign bus.spi_outgoing_data = hold_q;
    assign bus.idle              = (state_q == ST_IDLE) && tx_empty;
    assign bus.timeout_err       = err_q;

    quick_spi_fifo #(.WIDTH(TX_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (bus.tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    quick_spi_fifo #(.WIDTH(RX_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (bus.spi_incoming_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdy_d   = 1'b1;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_empty && !bus.spi_busy) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_pop  = 1'b1;
                hold_d  = tx_head;
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.spi_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.spi_busy) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A pop in the same cycle frees the slot, so a full FIFO still accepts.
                if (!rx_full || rx_pop) begin
                    rx_push = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_quick_spi_sequencer.sv
// tb/tb_quick_spi_sequencer.sv - randomized bench with SPI master model and queue-based reference
module tb_quick_spi_sequencer;
    import quick_spi_pkg::*;

    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    quick_spi_sequencer_if bus();

    logic       model_busy = 1'b0;
    logic       hold_busy  = 1'b0;
    logic [7:0] model_in   = 8'h00;
    assign bus.spi_busy          = model_busy | hold_busy;
    assign bus.spi_incoming_data = model_in;

    quick_spi_sequencer #(.TX_DEPTH(4), .RX_DEPTH(4), .START_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_tx[$];
    logic [7:0]  exp_rx[$];
    int   en_cnt = 0, last_en = -100, deliv_cnt = 0, rx_got = 0;
    bit   dead = 0, drop = 0, use_fixed = 0, model_active = 0;
    int   dly_lo = 1, dly_hi = 4, len_lo = 1, len_hi = 10;
    logic [7:0] fixed_in = 8'h00;
    int   ready_mode = 0;

    // SPI master model: every enable consumes the next expected word, returns one byte
    initial begin
        int dly, len;
        forever begin
            @(negedge clk);
            if (!reset && bus.spi_enable) begin
                en_cnt++;
                check("en_spacing", (cyc - last_en) >= 5, 1);
                last_en = cyc;
                if (exp_tx.size() == 0) check("en_unexpected", exp_tx.size(), 1);
                else check("out_data", bus.spi_outgoing_data, exp_tx.pop_front());
                @(negedge clk);
                check("en_one_cycle", bus.spi_enable, 0);
                if (!dead) begin
                    model_active = 1;
                    dly = $urandom_range(dly_hi, dly_lo);
                    len = $urandom_range(len_hi, len_lo);
                    repeat (dly) @(posedge clk);
                    #1;
                    model_busy = 1'b1;
                    model_in   = use_fixed ? fixed_in : 8'($urandom);
                    repeat (len) @(posedge clk);
                    #1;
                    model_busy = 1'b0;
                    if (!drop) begin
                        exp_rx.push_back(model_in);
                        deliv_cnt++;
                    end
                    model_active = 0;
                end
            end
        end
    end

    initial begin
        bus.rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.rx_ready = 1'b0;
                1:       bus.rx_ready = 1'b1;
                default: bus.rx_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.rx_valid && bus.rx_ready) begin
                rx_got++;
                if (exp_rx.size() == 0) check("rx_unexpected", exp_rx.size(), 1);
                else check("rx_data", bus.rx_data, exp_rx.pop_front());
            end
        end
    end

    task automatic send_words(int n, bit use_f, logic [15:0] fixed);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!bus.tx_ready && t < 1000) begin
                bus.tx_valid = 1'b0;
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 1000) begin
                check("tx_ready_timeout", bus.tx_ready, 1);
                break;
            end
            w = use_f ? fixed : 16'($urandom);
            bus.tx_valid = 1'b1;
            bus.tx_data  = w;
            exp_tx.push_back(w);
            @(posedge clk);
            #1;
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_drain(string tag, int limit);
        int t = 0;
        while (t < limit && !(exp_tx.size() == 0 && exp_rx.size() == 0 && bus.idle &&
                              !model_active && !bus.spi_busy)) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(tag, t < limit, 1);
    endtask

    task automatic check_reset_vals(string pfx);
        check({pfx, "_tx_ready"}, bus.tx_ready, 0);
        check({pfx, "_rx_valid"}, bus.rx_valid, 0);
        check({pfx, "_rx_data"}, bus.rx_data, 0);
        check({pfx, "_spi_enable"}, bus.spi_enable, 0);
        check({pfx, "_spi_out"}, bus.spi_outgoing_data, 0);
        check({pfx, "_timeout_err"}, bus.timeout_err, 0);
        check({pfx, "_idle"}, bus.idle, 1);
    endtask

    initial begin
        int e0, g0, d0, t, n;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("tx_ready_in_release", bus.tx_ready, 0);
        @(posedge clk);
        #1;
        check("tx_ready_rise", bus.tx_ready, 1);

        // Single word with fixed SPI timing and returned byte
        use_fixed = 1; fixed_in = 8'hC3;
        dly_lo = 2; dly_hi = 2; len_lo = 20; len_hi = 20;
        e0 = en_cnt;
        send_words(1, 1, 16'h5A5A);
        t = 0;
        while (!bus.rx_valid && t < 200) begin @(posedge clk); #1; t++; end
        check("t1_rx_valid", bus.rx_valid, 1);
        check("t1_rx_data", bus.rx_data, 8'hC3);
        check("t1_en_cnt", en_cnt - e0, 1);
        ready_mode = 1;
        wait_drain("t1_drain", 500);
        use_fixed = 0;
        dly_lo = 1; dly_hi = 4; len_lo = 1; len_hi = 10;

        // Four back-to-back writes fill the transmit FIFO
        hold_busy = 1'b1;
        e0 = en_cnt; g0 = rx_got;
        send_words(4, 0, 16'h0);
        check("t2_tx_full", bus.tx_ready, 0);
        check("t2_not_idle", bus.idle, 0);
        check("t2_no_enable_yet", en_cnt - e0, 0);
        hold_busy = 1'b0;
        wait_drain("t2_drain", 1000);
        check("t2_en_cnt", en_cnt - e0, 4);
        check("t2_rx_cnt", rx_got - g0, 4);

        // Full receive FIFO stalls CAPTURE; a single pop releases it
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        e0 = en_cnt; g0 = rx_got; d0 = deliv_cnt;
        send_words(5, 0, 16'h0);
        t = 0;
        while (deliv_cnt - d0 < 5 && t < 2000) begin @(posedge clk); #1; t++; end
        repeat (10) @(posedge clk);
        #1;
        check("t3_stall_idle", bus.idle, 0);
        check("t3_rx_valid", bus.rx_valid, 1);
        check("t3_en_cnt", en_cnt - e0, 5);
        @(negedge clk) ready_mode = 1;
        @(negedge clk) ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("t3_released", bus.idle, 1);
        check("t3_still_full", bus.rx_valid, 1);
        check("t3_one_pop", rx_got - g0, 1);
        ready_mode = 1;
        wait_drain("t3_drain", 500);
        check("t3_total", rx_got - g0, 5);

        // Busy never rises: timeout, word discarded, next word proceeds
        dead = 1;
        e0 = en_cnt;
        send_words(1, 0, 16'h0);
        t = 0;
        while (en_cnt == e0 && t < 100) begin @(negedge clk); t++; end
        t = 0;
        while (!bus.timeout_err && t < 400) begin @(negedge clk); t++; end
        n = cyc - last_en;
        check("t4_timeout_cycles", n, TO + 1);
        check("t4_err", bus.timeout_err, 1);
        check("t4_idle", bus.idle, 1);
        dead = 0;
        send_words(1, 0, 16'h0);
        wait_drain("t4_drain", 500);
        check("t4_sticky", bus.timeout_err, 1);
        check("t4_en_cnt", en_cnt - e0, 2);

        // Reset during WAIT_DONE drops the in-flight byte
        dly_lo = 1; dly_hi = 1; len_lo = 30; len_hi = 30;
        g0 = rx_got;
        send_words(1, 0, 16'h0);
        t = 0;
        while (!model_busy && t < 50) begin @(posedge clk); #1; t++; end
        repeat (4) @(posedge clk);
        #1;
        drop = 1;
        reset = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
        while (model_active && t < 100) begin @(posedge clk); #1; t++; end
        drop = 0;
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_rx", bus.rx_valid, 0);
        check("t5_idle", bus.idle, 1);
        check("t5_rx_got", rx_got - g0, 0);

        // Randomized traffic with random consumer back-pressure
        dly_lo = 1; dly_hi = 4; len_lo = 1; len_hi = 10;
        ready_mode = 2;
        e0 = en_cnt; g0 = rx_got;
        for (int i = 0; i < 12; i++) begin
            send_words(1, 0, 16'h0);
            repeat ($urandom_range(6, 0)) @(posedge clk);
            #1;
        end
        wait_drain("t6_drain", 3000);
        check("t6_en_cnt", en_cnt - e0, 12);
        check("t6_rx_cnt", rx_got - g0, 12);
        check("t6_err_cleared", bus.timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
